// File: rtl/demux_1to4_deser_if.sv
// +-----------------------------------------------------------------------------+
// | Module      : demux_1to4_deser_if                                           |
// | Description : Handshake bundle for the 1:4 serial-to-parallel receiver.     |
// |               Serial side : in_valid, in_bit, in_start -> ; <- in_ready     |
// |               Word side   : <- out_valid, out_data ; out_ready ->           |
// |               Status      : <- bit_idx (next slot), sync_err (resync pulse) |
// |               master = the agent driving the serial bits and out_ready,     |
// |               slave  = the receiver.                                        |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface demux_1to4_deser_if;
   logic       in_valid;
   logic       in_bit;
   logic       in_start;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [1:0] bit_idx;
   logic       sync_err;

   modport master (
      output in_valid, in_bit, in_start, out_ready,
      input  in_ready, out_valid, out_data, bit_idx, sync_err
   );

   modport slave (
      input  in_valid, in_bit, in_start, out_ready,
      output in_ready, out_valid, out_data, bit_idx, sync_err
   );
endinterface

`default_nettype wire

// File: rtl/demux_1to4_deser.sv
// +-----------------------------------------------------------------------------+
// | Module      : demux_1to4_deser                                              |
// | Description : Receiver end of the 4:1 bit-select serializer. Each accepted  |
// |               serial bit is steered into one of four word positions; every |
// |               completed 4-bit word is offered on a registered valid/ready   |
// |               port, with backpressure to the serial side.                   |
// | Ports       : clk  - rising-edge clock                                      |
// |               rst  - synchronous active-high reset                          |
// |               bus  - demux_1to4_deser_if.slave (serial in, word out,        |
// |                      bit_idx, sync_err)                                     |
// | Parameters  : LSB_FIRST - 1: bit k -> out_data[k]; 0: bit k -> out_data[3-k]|
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module demux_1to4_deser #(
   parameter int unsigned LSB_FIRST = 1
) (
   input  wire logic           clk,
   input  wire logic           rst,
   demux_1to4_deser_if.slave   bus
);

   logic [1:0] r_bit_idx;
   logic [3:0] r_asm;
   logic [3:0] r_out_data;
   logic       r_out_valid;
   logic       r_sync_err;

   logic       w_in_ready;
   logic       w_accept;
   logic       w_complete;
   logic [1:0] w_eff_idx;
   logic [1:0] w_pos;
   logic [3:0] w_asm_next;

   // Stall only when the 4th bit would overwrite a word still waiting downstream.
   assign w_in_ready = !((r_bit_idx == 2'd3) && r_out_valid && !bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   // A start bit always lands in slot 0 regardless of where the index was.
   assign w_eff_idx  = bus.in_start ? 2'd0 : r_bit_idx;
   assign w_pos      = (LSB_FIRST != 0) ? w_eff_idx : (2'd3 - w_eff_idx);

   // A start on what would be slot 3 resynchronises instead of completing.
   assign w_complete = w_accept && !bus.in_start && (r_bit_idx == 2'd3);

   always_comb begin
      w_asm_next        = bus.in_start ? 4'b0000 : r_asm;
      w_asm_next[w_pos] = bus.in_bit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_idx   <= 2'd0;
         r_asm       <= 4'b0000;
         r_out_data  <= 4'b0000;
         r_out_valid <= 1'b0;
         r_sync_err  <= 1'b0;
      end else begin
         r_sync_err <= w_accept && bus.in_start && (r_bit_idx != 2'd0);

         if (w_accept) begin
            r_bit_idx <= bus.in_start ? 2'd1 : (r_bit_idx + 2'd1);
            r_asm     <= w_complete ? 4'b0000 : w_asm_next;
         end

         // Completion wins over consumption so back-to-back words have no bubble.
         if (w_complete) begin
            r_out_data  <= w_asm_next;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.bit_idx   = r_bit_idx;
   assign bus.sync_err  = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_demux_1to4_deser.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_demux_1to4_deser                                           |
// | Description : Self-checking bench for demux_1to4_deser. Two instances       |
// |               (LSB_FIRST=1 and 0) share identical stimulus; expected words  |
// |               are queued when bits are driven and popped on each consume.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_demux_1to4_deser;

   logic clk;
   logic rst;
   logic r_in_valid;
   logic r_in_bit;
   logic r_in_start;
   logic r_out_ready;

   int n_checks;
   int n_pass;

   logic [3:0] q_lsb[$];
   logic [3:0] q_msb[$];

   demux_1to4_deser_if if_lsb ();
   demux_1to4_deser_if if_msb ();

   assign if_lsb.in_valid  = r_in_valid;
   assign if_lsb.in_bit    = r_in_bit;
   assign if_lsb.in_start  = r_in_start;
   assign if_lsb.out_ready = r_out_ready;
   assign if_msb.in_valid  = r_in_valid;
   assign if_msb.in_bit    = r_in_bit;
   assign if_msb.in_start  = r_in_start;
   assign if_msb.out_ready = r_out_ready;

   demux_1to4_deser #(.LSB_FIRST(1)) u_dut_lsb (.clk(clk), .rst(rst), .bus(if_lsb.slave));
   demux_1to4_deser #(.LSB_FIRST(0)) u_dut_msb (.clk(clk), .rst(rst), .bus(if_msb.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // b[k] is the k-th bit sent on the serial line.
   task automatic push_word(input logic [3:0] b);
      q_lsb.push_back(b);
      q_msb.push_back({b[0], b[1], b[2], b[3]});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic s);
      r_in_valid = 1'b1;
      r_in_bit   = b;
      r_in_start = s;
      tick();
      r_in_valid = 1'b0;
      r_in_start = 1'b0;
      r_in_bit   = 1'b0;
   endtask

   // Scoreboard: every consumed word must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && if_lsb.out_valid && if_lsb.out_ready) begin
         chk("lsb_q_has_word", 32'(q_lsb.size() > 0), 32'd1);
         if (q_lsb.size() > 0) chk("lsb_word", 32'(if_lsb.out_data), 32'(q_lsb.pop_front()));
      end
      if (!rst && if_msb.out_valid && if_msb.out_ready) begin
         chk("msb_q_has_word", 32'(q_msb.size() > 0), 32'd1);
         if (q_msb.size() > 0) chk("msb_word", 32'(if_msb.out_data), 32'(q_msb.pop_front()));
      end
   end

   initial begin
      logic [3:0]  wb;
      logic [11:0] sb;
      logic [1:0]  exp_idx;
      n_checks    = 0;
      n_pass      = 0;
      rst         = 1'b1;
      r_in_valid  = 1'b0;
      r_in_bit    = 1'b0;
      r_in_start  = 1'b0;
      r_out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      chk("rst_out_valid", 32'(if_lsb.out_valid), 32'd0);
      chk("rst_out_data",  32'(if_lsb.out_data),  32'd0);
      chk("rst_bit_idx",   32'(if_lsb.bit_idx),   32'd0);
      chk("rst_sync_err",  32'(if_lsb.sync_err),  32'd0);
      chk("rst_in_ready",  32'(if_lsb.in_ready),  32'd1);
      chk("rst_msb_valid", 32'(if_msb.out_valid), 32'd0);

      // Basic word 1,0,1,1: LSB-first 1101, MSB-first 1011
      wb = 4'b1101;
      push_word(wb);
      for (int k = 0; k < 4; k++) begin
         send_bit(wb[k], k == 0);
         exp_idx = 2'(k + 1);
         chk("basic_bit_idx",  32'(if_lsb.bit_idx),  32'(exp_idx));
         chk("basic_sync_err", 32'(if_lsb.sync_err), 32'd0);
         chk("basic_valid",    32'(if_lsb.out_valid), 32'(k == 3));
      end
      chk("basic_lsb_data", 32'(if_lsb.out_data), 32'hD);
      chk("basic_msb_data", 32'(if_msb.out_data), 32'hB);
      tick();
      chk("basic_valid_drop", 32'(if_lsb.out_valid), 32'd0);

      // Backpressure: word A held, word B's last bit stalls until out_ready
      r_out_ready = 1'b0;
      push_word(4'hA);
      for (int k = 0; k < 4; k++) send_bit(k[0], k == 0);
      chk("bp_a_valid", 32'(if_lsb.out_valid), 32'd1);
      chk("bp_a_data",  32'(if_lsb.out_data),  32'hA);
      wb = 4'h6;
      push_word(wb);
      for (int k = 0; k < 3; k++) begin
         r_in_valid = 1'b1;
         r_in_bit   = wb[k];
         #1;
         chk("bp_b_in_ready", 32'(if_lsb.in_ready), 32'd1);
         tick();
      end
      chk("bp_idx3",      32'(if_lsb.bit_idx),  32'd3);
      r_in_bit = wb[3];
      #1;
      chk("bp_stall_rdy", 32'(if_lsb.in_ready), 32'd0);
      tick();
      chk("bp_hold_idx",   32'(if_lsb.bit_idx),   32'd3);
      chk("bp_hold_data",  32'(if_lsb.out_data),  32'hA);
      chk("bp_hold_valid", 32'(if_lsb.out_valid), 32'd1);
      r_out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(if_lsb.in_ready), 32'd1);
      tick();
      r_in_valid  = 1'b0;
      r_out_ready = 1'b0;
      chk("bp_b_valid", 32'(if_lsb.out_valid), 32'd1);
      chk("bp_b_data",  32'(if_lsb.out_data),  32'h6);
      chk("bp_b_idx",   32'(if_lsb.bit_idx),   32'd0);
      r_out_ready = 1'b1;
      tick();
      chk("bp_drained", 32'(if_lsb.out_valid), 32'd0);

      // Continuous stream: 12 bits -> 3 single-cycle words, 4 cycles apart
      sb = 12'($urandom);
      for (int w = 0; w < 3; w++) push_word(sb[w*4 +: 4]);
      for (int i = 0; i < 12; i++) begin
         r_in_valid = 1'b1;
         r_in_bit   = sb[i];
         r_in_start = (i == 0);
         #1;
         chk("stream_in_ready", 32'(if_lsb.in_ready), 32'd1);
         tick();
         chk("stream_valid", 32'(if_lsb.out_valid), 32'((i % 4) == 3));
      end
      r_in_valid = 1'b0;
      r_in_start = 1'b0;
      tick();

      // Resync: 2 bits, then a start discards them
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      wb = 4'b1001;
      push_word(wb);
      send_bit(wb[0], 1'b1);
      chk("sync_err_pulse", 32'(if_lsb.sync_err), 32'd1);
      chk("sync_idx",       32'(if_lsb.bit_idx),  32'd1);
      for (int k = 1; k < 4; k++) begin
         send_bit(wb[k], 1'b0);
         chk("sync_err_clear", 32'(if_lsb.sync_err), 32'd0);
      end
      chk("sync_word", 32'(if_lsb.out_data), 32'h9);
      tick();

      // Reset with a held word and 3 partial bits, then a clean word
      r_out_ready = 1'b0;
      for (int k = 0; k < 4; k++) send_bit(1'b1, k == 0);
      for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0);
      chk("pre_rst_valid", 32'(if_lsb.out_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(if_lsb.out_valid), 32'd0);
      chk("mid_rst_data",  32'(if_lsb.out_data),  32'd0);
      chk("mid_rst_idx",   32'(if_lsb.bit_idx),   32'd0);
      r_out_ready = 1'b1;
      wb = 4'b0010;
      push_word(wb);
      for (int k = 0; k < 4; k++) send_bit(wb[k], 1'b0);
      chk("post_rst_lsb", 32'(if_lsb.out_data), 32'h2);
      chk("post_rst_msb", 32'(if_msb.out_data), 32'h4);
      repeat (2) tick();

      chk("lsb_q_empty", 32'(q_lsb.size()), 32'd0);
      chk("msb_q_empty", 32'(q_msb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
